// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default depth.
// Used by both the read-side and write-side pointer handlers.
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;
    localparam int DEPTH = 2 ** PTR_WIDTH_DEF;

    function automatic logic [31:0] bin2gray(
        input logic [31:0] i_b
    );
        return i_b ^ (i_b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(
        input logic [31:0] i_g
    );
        logic [31:0] r_b;
        r_b[31] = i_g[31];
        for (int i = 30; i >= 0; i--) begin
            r_b[i] = r_b[i+1] ^ i_g[i];
        end
        return r_b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Each binary bit is the parity of all Gray bits at or above it.
module gray2bin_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/rd_ptr_handler.sv
// Async FIFO read-side pointer handler: pointers, empty/almost-empty, count.
// Optional sticky underflow flag is built when RD_UNDERFLOW_EN is defined.
module rd_ptr_handler
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int AE_THRESH = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en,
    input  logic [PTR_WIDTH:0]   i_g_wr_ptr,
    output logic [PTR_WIDTH:0]   o_b_rd_ptr,
    output logic [PTR_WIDTH:0]   o_g_rd_ptr,
    output logic                 o_empty,
    output logic                 o_almost_empty,
    output logic [PTR_WIDTH:0]   o_rd_count
`ifdef RD_UNDERFLOW_EN
    ,
    input  logic                 i_clr_underflow,
    output logic                 o_underflow
`endif
);

    localparam int PW = PTR_WIDTH + 1;
    localparam int AE_INT = AE_THRESH;
    localparam logic [PTR_WIDTH:0] AE_L = AE_INT[PTR_WIDTH:0];

    logic [PTR_WIDTH:0] r_b_rd;
    logic [PTR_WIDTH:0] r_g_rd;
    logic               r_empty;
    logic               r_ae;
    logic [PTR_WIDTH:0] r_cnt;

    logic               w_rd_ok;
    logic [PTR_WIDTH:0] w_nxt_b;
    logic [PTR_WIDTH:0] w_nxt_g;
    logic [PTR_WIDTH:0] w_wr_bin;
    logic [PTR_WIDTH:0] w_cnt_nxt;

    gray2bin_conv #(
        .WIDTH (PW)
    ) u_wr_conv (
        .i_gray (i_g_wr_ptr),
        .o_bin  (w_wr_bin)
    );

    assign w_rd_ok   = i_en & ~r_empty;
    assign w_nxt_b   = r_b_rd + {{PTR_WIDTH{1'b0}}, w_rd_ok};
    assign w_nxt_g   = PW'(bin2gray(32'(w_nxt_b)));
    assign w_cnt_nxt = w_wr_bin - w_nxt_b;

    // Empty compares in Gray; the new write pointer is seen this same cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_b_rd  <= '0;
            r_g_rd  <= '0;
            r_empty <= 1'b1;
            r_ae    <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_b_rd  <= w_nxt_b;
            r_g_rd  <= w_nxt_g;
            r_empty <= (w_nxt_g == i_g_wr_ptr);
            r_ae    <= (w_cnt_nxt <= AE_L);
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_b_rd_ptr     = r_b_rd;
    assign o_g_rd_ptr     = r_g_rd;
    assign o_empty        = r_empty;
    assign o_almost_empty = r_ae;
    assign o_rd_count     = r_cnt;

`ifdef RD_UNDERFLOW_EN
    logic r_uf;

    // Set has priority over clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_uf <= 1'b0;
        end else if (i_en && r_empty) begin
            r_uf <= 1'b1;
        end else if (i_clr_underflow) begin
            r_uf <= 1'b0;
        end
    end

    assign o_underflow = r_uf;
`endif

endmodule

// File: tb/tb_rd_ptr_handler.sv
// Scoreboard bench for rd_ptr_handler (PTR_WIDTH=3, AE_THRESH=1).
// Build with +define+RD_UNDERFLOW_EN to also cover the underflow flag.
module tb_rd_ptr_handler;

    typedef struct {
        logic [3:0] b;
        logic       empty;
        logic       ae;
        logic [3:0] cnt;
        logic       uf;
        bit         onebit;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] g_wr;
    logic [3:0] b_rd;
    logic [3:0] g_rd;
    logic       empty;
    logic       ae;
    logic [3:0] cnt;
`ifdef RD_UNDERFLOW_EN
    logic       clr;
    logic       uf;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    logic [3:0] prev_g = '0;

    rd_ptr_handler #(
        .PTR_WIDTH (3),
        .AE_THRESH (1)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_en           (en),
        .i_g_wr_ptr     (g_wr),
        .o_b_rd_ptr     (b_rd),
        .o_g_rd_ptr     (g_rd),
        .o_empty        (empty),
        .o_almost_empty (ae),
        .o_rd_count     (cnt)
`ifdef RD_UNDERFLOW_EN
        ,
        .i_clr_underflow (clr),
        .o_underflow     (uf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] x;
        x = v[3:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(
        input logic e, input logic c, input int wr,
        input int eb, input int ee, input int ea,
        input int ec, input int eu, input bit ob
    );
        exp_t x;
        @(negedge clk);
        en   = e;
        g_wr = gray4(wr);
`ifdef RD_UNDERFLOW_EN
        clr  = c;
`else
        if (c) $display("note: clear ignored without underflow");
`endif
        x.b = eb[3:0];
        x.empty = ee[0];
        x.ae = ea[0];
        x.cnt = ec[3:0];
        x.uf = eu[0];
        x.onebit = ob;
        q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("b_rd_ptr", int'(b_rd), int'(e.b));
            chk("g_rd_ptr", int'(g_rd), int'(gray4(int'(e.b))));
            chk("empty", int'(empty), int'(e.empty));
            chk("almost_empty", int'(ae), int'(e.ae));
            chk("rd_count", int'(cnt), int'(e.cnt));
`ifdef RD_UNDERFLOW_EN
            chk("underflow", int'(uf), int'(e.uf));
`endif
            if (e.onebit)
                chk("gray_1bit", $countones(g_rd ^ prev_g), 1);
        end
        prev_g = g_rd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        g_wr = '0;
`ifdef RD_UNDERFLOW_EN
        clr  = 1'b0;
`endif
        #12;
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(cnt), 0);
        @(negedge clk);
        rstn = 1'b1;

        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        // read while empty: pointers hold
        step(1, 0, 0, 0, 1, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1, 0, 0, 0);

        // fill to 5 then drain
        step(0, 0, 5, 0, 0, 0, 5, 0, 0);
        step(1, 0, 5, 1, 0, 0, 4, 0, 1);
        step(1, 0, 5, 2, 0, 0, 3, 0, 1);
        step(1, 0, 5, 3, 0, 0, 2, 0, 1);
        step(1, 0, 5, 4, 0, 1, 1, 0, 1);
        step(1, 0, 5, 5, 1, 1, 0, 0, 1);

        // full depth at rd 5, then drain to rd 12
        step(0, 0, 13, 5, 0, 0, 8, 0, 0);
        for (int k = 1; k <= 7; k++)
            step(1, 0, 13, 5 + k, 0, ((8 - k) <= 1) ? 1 : 0,
                 8 - k, 0, 1);
        // full depth with wrapped write pointer
        step(0, 0, 4, 12, 0, 0, 8, 0, 0);

        // streaming wrap, write kept 8 ahead
        for (int i = 0; i < 20; i++)
            step(1, 0, (20 + i) % 16, (13 + i) % 16,
                 0, 0, 7, 0, 1);

        // last word read while write advances
        step(0, 0, 1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 2, 1, 0, 1, 1, 0, 1);

        // asynchronous reset mid-traffic
        @(negedge clk);
        en   = 1'b1;
        g_wr = gray4(3);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_b", int'(b_rd), 0);
        chk("mid_rst_g", int'(g_rd), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_ae", int'(ae), 1);
        chk("mid_rst_cnt", int'(cnt), 0);
        en   = 1'b0;
        g_wr = '0;
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rd_ptr_handler.md
Name: rd_ptr_handler

Overview:
Read-side pointer handler for the async FIFO, in the read clock domain. It owns the binary read pointer that addresses FIFO memory and the Gray read pointer that goes to the 2-FF synchroniser. It computes the registered empty flag, almost-empty flag and conservative fill level from the write pointer. That write pointer is already synchronised into the read domain.

Parameters:
PTR_WIDTH, 3, memory address width; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits (extra wrap bit)
AE_THRESH, 1, o_almost_empty asserts when fill level <= AE_THRESH; legal range 0..2**PTR_WIDTH-1

Ports:
i_clk  input  1  read-domain clock
i_rstn  input  1  asynchronous active-low reset
i_en  input  1  read request; honoured only when o_empty=0
i_g_wr_ptr  input  PTR_WIDTH+1  Gray write pointer, already synchronised to i_clk
o_b_rd_ptr  output  PTR_WIDTH+1  binary read pointer; memory uses [PTR_WIDTH-1:0]
o_g_rd_ptr  output  PTR_WIDTH+1  Gray read pointer to write-domain synchroniser
o_empty  output  1  FIFO empty, registered
o_almost_empty  output  1  fill level <= AE_THRESH, registered
o_rd_count  output  PTR_WIDTH+1  conservative fill level 0..2**PTR_WIDTH, registered
i_clr_underflow  input  1  clears o_underflow (present only with RD_UNDERFLOW_EN)
o_underflow  output  1  sticky underflow error (present only with RD_UNDERFLOW_EN)

Behaviour:
- Reset is asynchronous on i_rstn low, with synchronous release.
  - Reset values: o_b_rd_ptr=0, o_g_rd_ptr=0, o_empty=1, o_almost_empty=1, o_rd_count=0, o_underflow=0.
  - o_empty resets to 1, not 0.
- Read acceptance: rd_ok = i_en & ~o_empty.
- Next binary pointer: nxt_b = o_b_rd_ptr + rd_ok, modulo 2**(PTR_WIDTH+1). It wraps from all-ones to 0 with no special case.
- Next Gray pointer: nxt_g = nxt_b ^ (nxt_b >> 1).
- Empty: empty_nxt = (nxt_g == i_g_wr_ptr). The compare is done directly in Gray with no conversion.
- Fill level:
  - wr_bin = gray2bin(i_g_wr_ptr).
  - cnt_nxt = wr_bin - nxt_b, modulo 2**(PTR_WIDTH+1).
- Almost-empty: ae_nxt = (cnt_nxt <= AE_THRESH).
- All outputs are registered on the i_clk rising edge from their *_nxt values.
  - Latency is 1 cycle from an accepted read to the pointer, count and flag update.
  - Flags describe the state after the read just accepted.
- The read pointer advances by at most 1 per cycle. The memory read address is o_b_rd_ptr before the edge.
- Read while empty is ignored: pointers hold and no other state changes (underflow option excepted).
- Write-side lag:
  - o_empty deasserts no earlier than 2 read clocks after the write-side Gray pointer changes, because of the synchroniser.
  - o_rd_count is therefore an underestimate and is never more than the true fill.
- Simultaneous read of the last word and a synchronised write pointer change: empty_nxt uses the new i_g_wr_ptr, so the flag reflects both events in the same cycle.
- Illegal cnt_nxt above 2**PTR_WIDTH (broken synchroniser) is not checked.
- Reset mid-operation returns every output to its reset value immediately; the write side must be reset in the same window.

Optional Feature:
RD_UNDERFLOW_EN
- Defined:
  - o_underflow sets on any cycle with i_en=1 and o_empty=1. It is visible 1 cycle later and sticks.
  - i_clr_underflow=1 clears it; set wins over clear in the same cycle.
  - Pointers are unaffected by underflow.
- Undefined: i_clr_underflow and o_underflow ports are absent and no underflow logic is built.

Decomposition:
- Package fifo_pkg holds the gray2bin and bin2gray functions. It also holds a localparam for DEPTH = 2**PTR_WIDTH, shared with the write-side handler and the flag compare.
- One sub-module, gray2bin_conv (parameter WIDTH, purely combinational XOR prefix), converts i_g_wr_ptr to wr_bin.

Test Plan:
- Reset: i_rstn low mid-traffic -> all outputs at reset values within the same cycle; o_empty=1, o_rd_count=0.
- Fill then drain (PTR_WIDTH=3): drive i_g_wr_ptr=bin2gray(5) with o_b_rd_ptr=0.
  - 1 cycle later -> o_empty=0, o_rd_count=5, o_almost_empty=0.
  - Read 4 -> o_rd_count=1 and o_almost_empty=1.
  - 5th read -> o_empty=1, o_b_rd_ptr=5.
- Read while empty: i_en=1 held for 3 cycles with o_empty=1 -> o_b_rd_ptr and o_g_rd_ptr unchanged.
  - With RD_UNDERFLOW_EN: o_underflow=1 from the 2nd cycle; holds until i_clr_underflow pulses.
- Wrap: stream 20 reads against a write pointer kept ahead -> o_b_rd_ptr sequence 15 -> 0; o_g_rd_ptr changes exactly one bit per read.
- Full-depth count: i_g_wr_ptr=bin2gray(8) with rd ptr 0 -> o_rd_count=8, o_empty=0.
  - Same at rd ptr 12, wr 4 (wrapped) -> o_rd_count=8.
- Simultaneous event: read the last word while i_g_wr_ptr advances by 1 in the same cycle -> o_empty stays 0, o_rd_count=1.
